// File: rtl/csr_pkg.sv
// Shared CSR addresses, field positions, response codes and read FSM states
// for the machine-mode CSR register file.
package csr_pkg;

  localparam int DATA_W     = 32;
  localparam int CSR_ADDR_W = 12;

  localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS   = 12'h300;
  localparam logic [CSR_ADDR_W-1:0] CSR_MISA      = 12'h301;
  localparam logic [CSR_ADDR_W-1:0] CSR_MIE       = 12'h304;
  localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC     = 12'h305;
  localparam logic [CSR_ADDR_W-1:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [CSR_ADDR_W-1:0] CSR_MEPC      = 12'h341;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE    = 12'h342;
  localparam logic [CSR_ADDR_W-1:0] CSR_MTVAL     = 12'h343;
  localparam logic [CSR_ADDR_W-1:0] CSR_MIP       = 12'h344;
  localparam logic [CSR_ADDR_W-1:0] CSR_MVENDORID = 12'hF11;
  localparam logic [CSR_ADDR_W-1:0] CSR_MARCHID   = 12'hF12;
  localparam logic [CSR_ADDR_W-1:0] CSR_MIMPID    = 12'hF13;
  localparam logic [CSR_ADDR_W-1:0] CSR_MHARTID   = 12'hF14;

  localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [CSR_ADDR_W-1:0] CSR_CYCLE     = 12'hC00;
  localparam logic [CSR_ADDR_W-1:0] CSR_INSTRET   = 12'hC02;
  localparam logic [CSR_ADDR_W-1:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [CSR_ADDR_W-1:0] CSR_INSTRETH  = 12'hC82;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam int MIE_MSIE = 3;
  localparam int MIE_MTIE = 7;
  localparam int MIE_MEIE = 11;
  localparam logic [DATA_W-1:0] MIE_WMASK =
    (32'd1 << MIE_MSIE) | (32'd1 << MIE_MTIE) | (32'd1 << MIE_MEIE);

  localparam int MIP_MTIP = 7;
  localparam int MIP_MEIP = 11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently writable halves; a write to
// either half takes priority over the increment on that edge.
module csr_counter64
  import csr_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              wr_lo,
  input  logic              wr_hi,
  input  logic [DATA_W-1:0] wr_val,
  output logic [63:0]       count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) count[31:0]  <= wr_val;
      if (wr_hi) count[63:32] <= wr_val;
    end else if (inc) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR register file: registered AXI4-Lite read port, single-cycle
// write port, trap-state exports. Define CSR_COUNTERS_EN for mcycle/minstret.
module csr_regfile
  import csr_pkg::*;
#(
  parameter logic [DATA_W-1:0] HART_ID  = 32'd0,
  parameter logic [DATA_W-1:0] MISA_VAL = 32'h4000_0100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [CSR_ADDR_W-1:0] axil_csr_araddr,
  input  logic                  axil_csr_arvalid,
  output logic                  axil_csr_arready,
  output logic [DATA_W-1:0]     axil_csr_rdata,
  output logic [1:0]            axil_csr_rresp,
  output logic                  axil_csr_rvalid,
  input  logic                  axil_csr_rready,
  input  logic [CSR_ADDR_W-1:0] csr_write_addr,
  input  logic [DATA_W-1:0]     csr_write_val,
  input  logic                  csr_write_valid,
  input  logic                  instret_inc,
  input  logic                  timer_irq,
  input  logic                  ext_irq,
  output logic [DATA_W-1:0]     mtvec_out,
  output logic [DATA_W-1:0]     mepc_out,
  output logic                  mstatus_mie_out,
  output logic [DATA_W-1:0]     mie_out
);

  function automatic logic [DATA_W-1:0] align4(input logic [DATA_W-1:0] v);
    return {v[DATA_W-1:2], 2'b00};
  endfunction

  logic              mstatus_mie_q;
  logic              mstatus_mpie_q;
  logic [DATA_W-1:0] mie_q;
  logic [DATA_W-1:0] mtvec_q;
  logic [DATA_W-1:0] mscratch_q;
  logic [DATA_W-1:0] mepc_q;
  logic [DATA_W-1:0] mcause_q;
  logic [DATA_W-1:0] mtval_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= '0;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
    end else if (csr_write_valid) begin
      case (csr_write_addr)
        CSR_MSTATUS: begin
          mstatus_mie_q  <= csr_write_val[MSTATUS_MIE];
          mstatus_mpie_q <= csr_write_val[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_q      <= csr_write_val & MIE_WMASK;
        CSR_MTVEC:    mtvec_q    <= align4(csr_write_val);
        CSR_MSCRATCH: mscratch_q <= csr_write_val;
        CSR_MEPC:     mepc_q     <= align4(csr_write_val);
        CSR_MCAUSE:   mcause_q   <= csr_write_val;
        CSR_MTVAL:    mtval_q    <= csr_write_val;
        default: ;
      endcase
    end
  end

  assign mtvec_out       = mtvec_q;
  assign mepc_out        = mepc_q;
  assign mstatus_mie_out = mstatus_mie_q;
  assign mie_out         = mie_q;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle;
  logic [63:0] minstret;

  csr_counter64 u_mcycle (
    .clk    (clk),
    .reset  (reset),
    .inc    (1'b1),
    .wr_lo  (csr_write_valid && (csr_write_addr == CSR_MCYCLE)),
    .wr_hi  (csr_write_valid && (csr_write_addr == CSR_MCYCLEH)),
    .wr_val (csr_write_val),
    .count  (mcycle)
  );

  csr_counter64 u_minstret (
    .clk    (clk),
    .reset  (reset),
    .inc    (instret_inc),
    .wr_lo  (csr_write_valid && (csr_write_addr == CSR_MINSTRET)),
    .wr_hi  (csr_write_valid && (csr_write_addr == CSR_MINSTRETH)),
    .wr_val (csr_write_val),
    .count  (minstret)
  );
`else
  logic unused_instret;
  assign unused_instret = instret_inc;
`endif

  logic [DATA_W-1:0] mstatus_rd;
  logic [DATA_W-1:0] mip_rd;
  logic [DATA_W-1:0] rd_data_c;
  logic [1:0]        rd_resp_c;

  always_comb begin
    mstatus_rd                              = '0;
    mstatus_rd[MSTATUS_MIE]                 = mstatus_mie_q;
    mstatus_rd[MSTATUS_MPIE]                = mstatus_mpie_q;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mip_rd                                  = '0;
    mip_rd[MIP_MTIP]                        = timer_irq;
    mip_rd[MIP_MEIP]                        = ext_irq;
  end

  always_comb begin
    rd_data_c = '0;
    rd_resp_c = RESP_OKAY;
    case (axil_csr_araddr)
      CSR_MSTATUS:   rd_data_c = mstatus_rd;
      CSR_MISA:      rd_data_c = MISA_VAL;
      CSR_MIE:       rd_data_c = mie_q;
      CSR_MTVEC:     rd_data_c = mtvec_q;
      CSR_MSCRATCH:  rd_data_c = mscratch_q;
      CSR_MEPC:      rd_data_c = mepc_q;
      CSR_MCAUSE:    rd_data_c = mcause_q;
      CSR_MTVAL:     rd_data_c = mtval_q;
      CSR_MIP:       rd_data_c = mip_rd;
      CSR_MVENDORID,
      CSR_MARCHID,
      CSR_MIMPID:    rd_data_c = '0;
      CSR_MHARTID:   rd_data_c = HART_ID;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE,   CSR_CYCLE:    rd_data_c = mcycle[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:   rd_data_c = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:  rd_data_c = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: rd_data_c = minstret[63:32];
`endif
      default:       rd_resp_c = RESP_SLVERR;
    endcase
  end

  // Stage p1: response registered at the accept edge, held until rready
  rd_state_e         state_q;
  rd_state_e         state_d;
  logic              accept;
  logic [DATA_W-1:0] rdata_p1;
  logic [1:0]        rresp_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RD_IDLE;
      rdata_p1 <= '0;
      rresp_p1 <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rdata_p1 <= rd_data_c;
        rresp_p1 <= rd_resp_c;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    accept           = 1'b0;
    axil_csr_arready = 1'b0;
    axil_csr_rvalid  = 1'b0;
    case (state_q)
      RD_IDLE: begin
        axil_csr_arready = 1'b1;
        if (axil_csr_arvalid && !flush) begin
          accept  = 1'b1;
          state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        axil_csr_rvalid = 1'b1;
        if (flush || axil_csr_rready) state_d = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
  end

  assign axil_csr_rdata = rdata_p1;
  assign axil_csr_rresp = rresp_p1;

endmodule
